// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Used by debounce_ch and debounce_bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } db_state_e;

  // Bits needed to count 0..max(a,b)-1, never below one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: synchroniser, debounce FSM,
// shared dwell counter and registered event pulses.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 5000,
  parameter int LONG_CYCLES = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = cnt_width(DB_CYCLES, LONG_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_e              state;
  db_state_e              state_n;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_n;
  logic                   long_done;
  logic                   long_done_n;
  logic                   press_n;
  logic                   release_n;
  logic                   long_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    long_done_n = long_done;
    press_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n       = '0;
        long_done_n = 1'b0;
        if (s) state_n = DB_PRESS;
      end
      DB_PRESS: begin
        if (!s) begin
          state_n = IDLE;
        end else if (cnt < DB_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = HELD;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end else begin
          if (cnt < LONG_LAST) cnt_n = cnt + 1'b1;
          if (cnt == LONG_LAST && !long_done) begin
            long_n      = 1'b1;
            long_done_n = 1'b1;
          end
        end
      end
      DB_RELEASE: begin
        // A bounce back to high resumes the hold; long_done survives it.
        if (s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt < DB_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n   = IDLE;
          cnt_n     = '0;
          release_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      long_done     <= long_done_n;
      btn_level     <= (state_n == HELD) || (state_n == DB_RELEASE);
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced button channels for the
// lock front panel; one debounce_ch per button.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 5000,
  parameter int LONG_CYCLES = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  if (N_CH < 1)        begin : g_bad_nch  $error("N_CH must be >= 1");        end
  if (DB_CYCLES < 1)   begin : g_bad_db   $error("DB_CYCLES must be >= 1");   end
  if (LONG_CYCLES < 1) begin : g_bad_long $error("LONG_CYCLES must be >= 1"); end
  if (SYNC_STAGES < 2) begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expected pulse events are
// queued with their due edge and matched against outputs each cycle.
module tb_debounce_bank;

  localparam int N  = 2;
  localparam int KP = 0;
  localparam int KR = 1;
  localparam int KL = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  ev_t sb[$];

  debounce_bank #(
    .N_CH       (N),
    .DB_CYCLES  (4),
    .LONG_CYCLES(10),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got=%0h want=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic push(input int cyc, input int kind, input int ch);
    ev_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    logic [N-1:0] ep;
    logic [N-1:0] er;
    logic [N-1:0] el;
    ep = '0;
    er = '0;
    el = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_n) begin
        case (sb[i].kind)
          KP:      ep[sb[i].ch] = 1'b1;
          KR:      er[sb[i].ch] = 1'b1;
          default: el[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    chk("press", 32'(press_pulse), 32'(ep));
    chk("release", 32'(release_pulse), 32'(er));
    chk("long", 32'(long_pulse), 32'(el));
  end

  initial begin : stim
    int e;
    step(3);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_press", 32'(press_pulse), 0);
    rst = 1'b0;
    step(2);

    // clean press, long press with a post-long glitch, release
    btn_in = 2'b01;
    e = edge_n;
    push(e + 7, KP, 0);
    push(e + 17, KL, 0);
    step(6);
    chk("clean_lvl_pre", 32'(btn_level), 0);
    step(1);
    chk("clean_lvl", 32'(btn_level), 32'b01);
    step(13);
    btn_in = 2'b00;
    step(2);
    btn_in = 2'b01;
    chk("glitch_lvl", 32'(btn_level), 32'b01);
    step(15);
    btn_in = 2'b00;
    e = edge_n;
    push(e + 7, KR, 0);
    step(6);
    chk("rel_lvl_pre", 32'(btn_level), 32'b01);
    step(1);
    chk("rel_lvl", 32'(btn_level), 0);
    step(5);

    // bounce: 3 high / 1 low five times, then stable high
    for (int k = 0; k < 5; k++) begin
      btn_in = 2'b01;
      step(3);
      btn_in = 2'b00;
      step(1);
    end
    chk("bounce_lvl", 32'(btn_level), 0);
    btn_in = 2'b01;
    e = edge_n;
    push(e + 7, KP, 0);
    step(8);
    btn_in = 2'b00;
    e = edge_n;
    push(e + 7, KR, 0);
    step(10);

    // release glitch while held
    btn_in = 2'b01;
    e = edge_n;
    push(e + 7, KP, 0);
    step(8);
    btn_in = 2'b00;
    step(2);
    btn_in = 2'b01;
    chk("rg_lvl_a", 32'(btn_level), 32'b01);
    step(2);
    chk("rg_lvl_b", 32'(btn_level), 32'b01);
    step(2);
    btn_in = 2'b00;
    e = edge_n;
    push(e + 7, KR, 0);
    step(7);
    chk("rg_lvl_end", 32'(btn_level), 0);
    step(3);

    // simultaneous channels
    btn_in = 2'b11;
    e = edge_n;
    push(e + 7, KP, 0);
    push(e + 7, KP, 1);
    push(e + 17, KL, 0);
    step(7);
    chk("sim_lvl", 32'(btn_level), 32'b11);
    step(3);
    btn_in = 2'b01;
    push(edge_n + 7, KR, 1);
    step(7);
    chk("sim_lvl_ch0", 32'(btn_level), 32'b01);
    step(2);
    btn_in = 2'b00;
    push(edge_n + 7, KR, 0);
    step(10);

    // reset during DB_PRESS
    btn_in = 2'b01;
    step(4);
    rst = 1'b1;
    #1;
    chk("rst_dbp_lvl", 32'(btn_level), 0);
    step(2);
    rst = 1'b0;
    e = edge_n;
    push(e + 7, KP, 0);
    step(6);
    chk("rst_dbp_pre", 32'(btn_level), 0);
    step(1);
    chk("rst_dbp_post", 32'(btn_level), 32'b01);
    step(3);

    // reset during HELD
    rst = 1'b1;
    #1;
    chk("rst_held_lvl", 32'(btn_level), 0);
    chk("rst_held_long", 32'(long_pulse), 0);
    step(2);
    rst = 1'b0;
    e = edge_n;
    push(e + 7, KP, 0);
    step(6);
    chk("rst_held_pre", 32'(btn_level), 0);
    step(1);
    chk("rst_held_post", 32'(btn_level), 32'b01);
    step(1);
    btn_in = 2'b00;
    push(edge_n + 7, KR, 0);
    step(12);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner for the electronic lock front panel. Each channel synchronises one raw button, debounces press and release, and reports a clean level plus single-cycle press, release and long-press pulses. It replaces per-button single-purpose debouncers, including the reset-button debouncer. It sits between the raw keypad/button pins and the lock control FSM.

## Interface
- N_CH, 4, number of independent button channels (≥1)
- DB_CYCLES, 5000, consecutive stable cycles required to accept a press or release (≥1)
- LONG_CYCLES, 100000, cycles a press must remain held before long_pulse fires (≥1)
- SYNC_STAGES, 2, input synchroniser depth (≥2)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high; clock clk
- btn_in  input  N_CH  raw active-high buttons, asynchronous to clk
- btn_level  output  N_CH  debounced button state
- press_pulse  output  N_CH  one-cycle pulse on accepted press
- release_pulse  output  N_CH  one-cycle pulse on accepted release
- long_pulse  output  N_CH  one-cycle pulse, once per press, after LONG_CYCLES held

## Operation
- Channels are fully independent. No cross-channel priority or interaction.
- Per channel: btn_in passes through a SYNC_STAGES flop chain (reset 0). The output s drives the FSM.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE. A single counter cnt is used. Width is clog2(max(DB_CYCLES, LONG_CYCLES)). A long_done flag is also kept.
- IDLE: cnt←0, long_done←0. If s=1, go to DB_PRESS.
- DB_PRESS: if s=0, return to IDLE with no output. Else if cnt<DB_CYCLES−1, increment cnt. Else go to HELD with cnt←0 and assert press_pulse.
- HELD: if s=0, go to DB_RELEASE with cnt←0. Otherwise cnt increments and saturates at LONG_CYCLES−1. When cnt=LONG_CYCLES−1 and long_done=0, assert long_pulse and set long_done←1.
- DB_RELEASE: if s=1, return to HELD with cnt←0. This return asserts no press_pulse and leaves long_done unchanged. Else if cnt<DB_CYCLES−1, increment cnt. Else go to IDLE and assert release_pulse.
- btn_level=1 exactly while the state is HELD or DB_RELEASE.
- All outputs are registered.

## Timing
- Reset: all states are IDLE, counters and synchronisers are 0, and all outputs are 0. This takes effect immediately and asynchronously, including mid-debounce or mid-hold.
- Press latency: suppose btn_in is high before edge 1 and stays high. The channel enters HELD at edge SYNC_STAGES+1+DB_CYCLES. btn_level rises and press_pulse is high for that one cycle.
- Release latency: counted from the first edge sampling btn_in low, it is also SYNC_STAGES+1+DB_CYCLES edges. btn_level falls and release_pulse is high for one cycle.
- long_pulse fires LONG_CYCLES cycles after press_pulse. It fires at most once per press, even across release glitches.
- Any bounce shorter than DB_CYCLES restarts the debounce. No pulse is emitted.
- In any channel, press_pulse, release_pulse and long_pulse are never high in the same cycle.

## Structure
- The package debounce_pkg holds:
  - the state enum {IDLE, DB_PRESS, HELD, DB_RELEASE}
  - a counter-width helper function
- Sub-module debounce_ch implements one channel: synchroniser, FSM, counter and flags. debounce_bank instantiates it N_CH times with a generate loop.
- Parameter legality is checked at elaboration: DB_CYCLES≥1, LONG_CYCLES≥1, SYNC_STAGES≥2.

## Test plan
All scenarios use N_CH=2, DB_CYCLES=4, LONG_CYCLES=10, SYNC_STAGES=2.
- Clean press: btn_in[0]=1 from edge 1, held → press_pulse[0]=1 only in the cycle after edge 7, and btn_level[0]=1 from edge 7. Channel 1 outputs stay 0.
- Bounce: btn_in[0] high 3 cycles, low 1, repeated 5 times, then stable high → no pulse during the bounce. press_pulse fires 7 edges after the final rise.
- Long press: hold btn_in[0] 30 cycles after press → long_pulse[0] fires exactly once, 10 cycles after press_pulse. There is no repeat.
- Release glitch: while in HELD, drop btn_in[0] for 2 cycles, then keep it high → btn_level stays 1 with no release or press pulse. A later stable low gives release_pulse 7 edges after the fall.
- Simultaneous channels: both buttons rise on the same edge → both press_pulse bits are high in the same cycle. Releasing only channel 1 leaves channel 0 held.
- Reset mid-operation: assert rst during DB_PRESS and again during HELD → all outputs go to 0 immediately. After rst deasserts with the button still high, the full 7-edge latency applies again.
